// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and constants for the seven-segment scan stage.
// Imported by the scan interface, the tick counter and the scanner top.
package seven_seg_scanner_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    FIELD_NONE    = 2'd0,
    FIELD_HOURS   = 2'd1,
    FIELD_MINUTES = 2'd2,
    FIELD_RSVD    = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    POS_MIN_U = 2'd0,
    POS_MIN_T = 2'd1,
    POS_HR_U  = 2'd2,
    POS_HR_T  = 2'd3
  } pos_e;

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
  } hhmm_t;

  function automatic logic [3:0] pick_digit(
    input hhmm_t      t,
    input logic [1:0] pos
  );
    logic [3:0] d;
    d = t.min_u;
    unique case (1'b1)
      pos == POS_MIN_U: d = t.min_u;
      pos == POS_MIN_T: d = t.min_t;
      pos == POS_HR_U:  d = t.hr_u;
      pos == POS_HR_T:  d = t.hr_t;
      default:          d = t.min_u;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Bundle between the time/alarm source, the scanner and the digit decoder.
// master = scanner side, slave = source/decoder side.
interface seven_seg_scanner_if;
  import seven_seg_scanner_pkg::*;

  logic       show_alarm;
  logic [1:0] edit_field;
  logic [3:0] clk_hr_t;
  logic [3:0] clk_hr_u;
  logic [3:0] clk_min_t;
  logic [3:0] clk_min_u;
  logic [3:0] alm_hr_t;
  logic [3:0] alm_hr_u;
  logic [3:0] alm_min_t;
  logic [3:0] alm_min_u;
  logic [1:0] en;
  logic [3:0] num;
  logic       en_clock;

  modport master (
    input  show_alarm, edit_field,
    input  clk_hr_t, clk_hr_u, clk_min_t, clk_min_u,
    input  alm_hr_t, alm_hr_u, alm_min_t, alm_min_u,
    output en, num, en_clock
  );

  modport slave (
    output show_alarm, edit_field,
    output clk_hr_t, clk_hr_u, clk_min_t, clk_min_u,
    output alm_hr_t, alm_hr_u, alm_min_t, alm_min_u,
    input  en, num, en_clock
  );

endinterface

// File: rtl/seven_seg_scanner_tick.sv
// Mod-N counter with a one-cycle terminal-count pulse and sync clear.
// Used for both the digit-slot timer and the blink timer.
module mod_n_tick #(
  parameter int N = 4,
  parameter int W = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Digit scan stage: steps the display position, picks clock or alarm
// digits and blanks the field under adjustment at the blink rate.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000,
  parameter int CNT_W     = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scanner_if.master   bus
);

  logic       scan_tick;
  logic       blink_tick;
  logic       blink_on;
  logic       edit_chg;
  logic [1:0] edit_q;
  logic [1:0] next_en;
  logic [3:0] next_num;
  logic       blank;
  hhmm_t      clk_t;
  hhmm_t      alm_t;
  hhmm_t      src;

  mod_n_tick #(
    .N (SCAN_DIV),
    .W (CNT_W)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  // An edit-field change restarts the blink phase so the new field shows at once.
  mod_n_tick #(
    .N (BLINK_DIV),
    .W (CNT_W)
  ) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (edit_chg),
    .tick  (blink_tick)
  );

  assign edit_chg = (bus.edit_field != edit_q);

  assign clk_t = '{hr_t:  bus.clk_hr_t,
                   hr_u:  bus.clk_hr_u,
                   min_t: bus.clk_min_t,
                   min_u: bus.clk_min_u};
  assign alm_t = '{hr_t:  bus.alm_hr_t,
                   hr_u:  bus.alm_hr_u,
                   min_t: bus.alm_min_t,
                   min_u: bus.alm_min_u};

  always_comb begin
    next_en  = bus.en + 2'd1;
    src      = bus.show_alarm ? alm_t : clk_t;
    blank    = 1'b0;
    unique case (1'b1)
      bus.edit_field == FIELD_HOURS:   blank = next_en[1];
      bus.edit_field == FIELD_MINUTES: blank = !next_en[1];
      default:                         blank = 1'b0;
    endcase
    blank    = blank && !blink_on;
    next_num = blank ? DIGIT_BLANK : pick_digit(src, next_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edit_q   <= FIELD_NONE;
      blink_on <= 1'b1;
    end else begin
      edit_q <= bus.edit_field;
      if (edit_chg) begin
        blink_on <= 1'b1;
      end else if (blink_tick) begin
        blink_on <= !blink_on;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.en  <= POS_MIN_U;
      bus.num <= DIGIT_BLANK;
    end else if (scan_tick) begin
      bus.en  <= next_en;
      bus.num <= next_num;
    end
  end

  assign bus.en_clock = !bus.show_alarm &&
                        (bus.edit_field[0] == bus.edit_field[1]);

endmodule
